timer_alarm: RTL and testbench

- Compare/alarm stage downstream of the timer core. Consumes the free-running 64-bit TIMER_VALUE and raises an interrupt when the count reaches a programmed 64-bit compare value.
- Supports one-shot and periodic (auto-reload) modes and flags missed periods.
- Sits beside the timer peripheral's software register file. The register file drives the cfg_* write port.

---
 rtl/timer_alarm_pkg.sv | 24 ++
 rtl/timer_alarm_cmp.sv | 16 +
 rtl/timer_alarm.sv | 127 ++++++++++++
 tb/tb_timer_alarm.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_alarm_pkg.sv
// Shared constants for the timer compare/alarm stage: register addresses,
// CTRL bit positions, FSM state encoding and default widths.
package timer_alarm_pkg;

  localparam int TIMER_ALARM_DATA_W = 32;
  localparam int TIMER_ALARM_CNT_W  = 64;

  localparam logic [1:0] TIMER_ALARM_CMP_LOW  = 2'd0;
  localparam logic [1:0] TIMER_ALARM_CMP_HIGH = 2'd1;
  localparam logic [1:0] TIMER_ALARM_PERIOD   = 2'd2;
  localparam logic [1:0] TIMER_ALARM_CTRL     = 2'd3;

  localparam int CTRL_ARM      = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_CLR_PEND = 2;
  localparam int CTRL_CLR_OVR  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } alarm_state_e;

endpackage

// File: rtl/timer_alarm_cmp.sv
// Wrap-safe "reached" comparator: the count has reached the target when
// (count - target) mod 2^CNT_W has a clear sign bit.
module timer_alarm_cmp #(
  parameter int CNT_W = 64
) (
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] target,
  output logic             reached
);

  logic [CNT_W-1:0] diff;

  assign diff    = count - target;
  assign reached = ~diff[CNT_W-1];

endmodule

// File: rtl/timer_alarm.sv
// Compare/alarm stage: raises a sticky interrupt when the timer reaches the
// programmed compare value, with one-shot and auto-reload modes.
// Optional build macro TIMER_ALARM_OVERRUN_EN adds the overrun flag and miss_cnt.
//
// state    | meaning
// ST_IDLE  | no compare activity
// ST_ARMED | compare evaluated every cycle, fires when reached
// ST_FIRED | one-shot complete; only a CTRL arm write leaves
module timer_alarm
  import timer_alarm_pkg::*;
#(
  parameter int DATA_W = TIMER_ALARM_DATA_W,
  parameter int CNT_W  = TIMER_ALARM_CNT_W  // must be 2*DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  timer_value,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              armed,
  output logic              pending,
  output logic              irq,
  output logic              overrun,
  output logic [CNT_W-1:0]  cmp_value
`ifdef TIMER_ALARM_OVERRUN_EN
  ,
  output logic [7:0]        miss_cnt
`endif
);

  alarm_state_e      state;
  logic [CNT_W-1:0]  period;
  logic [DATA_W-1:0] shadow_low;
  logic              periodic;

  logic reached;
  logic ctrl_wr;
  logic fire;
  logic reload;

  timer_alarm_cmp #(.CNT_W(CNT_W)) u_cmp (
    .count   (timer_value),
    .target  (cmp_value),
    .reached (reached)
  );

  // A disarm write in the same cycle suppresses the fire entirely.
  always_comb begin
    ctrl_wr = cfg_we && (cfg_addr == TIMER_ALARM_CTRL);
    fire    = (state == ST_ARMED) && reached && !(ctrl_wr && !cfg_wdata[CTRL_ARM]);
    reload  = fire && periodic && (period != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      armed      <= 1'b0;
      pending    <= 1'b0;
      cmp_value  <= '0;
      period     <= '0;
      shadow_low <= '0;
      periodic   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        state    <= cfg_wdata[CTRL_ARM] ? ST_ARMED : ST_IDLE;
        armed    <= cfg_wdata[CTRL_ARM];
        periodic <= cfg_wdata[CTRL_PERIODIC];
      end else if (fire && !reload) begin
        state <= ST_FIRED;
        armed <= 1'b0;
      end

      if (cfg_we && (cfg_addr == TIMER_ALARM_CMP_LOW))
        shadow_low <= cfg_wdata;

      // A software commit overrides the auto-reload of the same cycle.
      if (cfg_we && (cfg_addr == TIMER_ALARM_CMP_HIGH))
        cmp_value <= {cfg_wdata, shadow_low};
      else if (reload)
        cmp_value <= cmp_value + period;

      if (cfg_we && (cfg_addr == TIMER_ALARM_PERIOD))
        period <= {{(CNT_W-DATA_W){1'b0}}, cfg_wdata};

      if (fire)
        pending <= 1'b1;
      else if (ctrl_wr && cfg_wdata[CTRL_CLR_PEND])
        pending <= 1'b0;
    end
  end

  assign irq = pending;

`ifdef TIMER_ALARM_OVERRUN_EN
  logic missed;
  logic clr_ovr;

  assign missed  = fire && pending;
  assign clr_ovr = ctrl_wr && cfg_wdata[CTRL_CLR_OVR];

  // Clear is applied before a coincident miss, so the miss still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      miss_cnt <= '0;
    end else begin
      if (missed)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;

      if (missed) begin
        if (clr_ovr)
          miss_cnt <= 8'd1;
        else if (miss_cnt != 8'hFF)
          miss_cnt <= miss_cnt + 8'd1;
      end else if (clr_ovr) begin
        miss_cnt <= '0;
      end
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_timer_alarm.sv
// Self-checking bench for timer_alarm: a behavioural register/flag model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_timer_alarm;
  import timer_alarm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] timer_value = 64'd0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic        armed, pending, irq, overrun;
  logic [63:0] cmp_value;
`ifdef TIMER_ALARM_OVERRUN_EN
  logic [7:0]  miss_cnt;
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  timer_alarm dut (
    .clk         (clk),
    .rst         (rst),
    .timer_value (timer_value),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .armed       (armed),
    .pending     (pending),
    .irq         (irq),
    .overrun     (overrun),
    .cmp_value   (cmp_value)
`ifdef TIMER_ALARM_OVERRUN_EN
    ,
    .miss_cnt    (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Software-visible behaviour: IDLE and FIRED are indistinguishable from
  // outside, so the model keeps only an "armed" bit.
  typedef struct packed {
    logic        armed;
    logic        pending;
    logic        overrun;
    logic [7:0]  miss;
    logic [63:0] cmp;
    logic [63:0] period;
    logic [31:0] shadow;
    logic        periodic;
  } model_t;

  model_t m = '0;

  function automatic model_t step(model_t c, logic r, logic [63:0] tv, logic we,
                                  logic [1:0] a, logic [31:0] wd);
    model_t n;
    logic   fire;
    if (r) return '0;
    n    = c;
    fire = c.armed && ($signed(tv - c.cmp) >= 64'sd0) && !(we && a == 2'd3 && !wd[0]);
    if (fire) begin
      if (c.periodic && c.period != 64'd0) n.cmp = c.cmp + c.period;
      else n.armed = 1'b0;
    end
    if (we) begin
      case (a)
        2'd0: n.shadow = wd;
        2'd1: n.cmp    = {wd, c.shadow};
        2'd2: n.period = {32'd0, wd};
        default: begin
          n.armed    = wd[0];
          n.periodic = wd[1];
          if (wd[2]) n.pending = 1'b0;
          if (wd[3] && OVR_EN) begin
            n.overrun = 1'b0;
            n.miss    = 8'd0;
          end
        end
      endcase
    end
    if (fire) begin
      n.pending = 1'b1;
      if (c.pending && OVR_EN) begin
        n.overrun = 1'b1;
        if (n.miss != 8'hFF) n.miss = n.miss + 8'd1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst, timer_value, cfg_we, cfg_addr, cfg_wdata);

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("armed",     64'(armed),     64'(m.armed));
    chk("pending",   64'(pending),   64'(m.pending));
    chk("irq",       64'(irq),       64'(m.pending));
    chk("overrun",   64'(overrun),   64'(m.overrun));
    chk("cmp_value", cmp_value,      m.cmp);
`ifdef TIMER_ALARM_OVERRUN_EN
    chk("miss_cnt",  64'(miss_cnt),  64'(m.miss));
`endif
  endtask

  // Outputs are checked on the falling edge; inputs change 1 after the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) compare_all();
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    timer_value = timer_value + 64'd1;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    cyc();
  endtask

  task automatic run_until(logic [63:0] target);
    int n = 0;
    while (timer_value != target && n < 3000) begin
      cyc();
      n++;
    end
    if (timer_value != target) begin
      checks++;
      failures++;
      $display("FAIL run_until actual=%h required=%h", timer_value, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset, then idle with the counter running
    cyc();
    chk_en = 1'b1;
    rst    = 1'b0;
    repeat (100) cyc();
    chk("idle_armed",   64'(armed),   64'd0);
    chk("idle_pending", 64'(pending), 64'd0);
    chk("idle_irq",     64'(irq),     64'd0);
    chk("idle_cmp",     cmp_value,    64'd0);

    // One-shot at 0x100
    timer_value = 64'd0;
    wr(TIMER_ALARM_CMP_LOW, 32'h100);
    wr(TIMER_ALARM_CMP_HIGH, 32'h0);
    wr(TIMER_ALARM_CTRL, 32'h1);
    n = 0;
    while (irq !== 1'b1 && n < 1000) begin
      cyc();
      n++;
    end
    chk("oneshot_irq_time", timer_value, 64'h101);
    chk("oneshot_armed",    64'(armed),  64'd0);
    repeat (3) cyc();
    wr(TIMER_ALARM_CTRL, 32'h4);
    chk("oneshot_clear", 64'(pending), 64'd0);

    // Periodic 0x10 + n*0x20, never cleared
    wr(TIMER_ALARM_CTRL, 32'h0);
    timer_value = 64'd0;
    wr(TIMER_ALARM_CMP_LOW, 32'h10);
    wr(TIMER_ALARM_CMP_HIGH, 32'h0);
    wr(TIMER_ALARM_PERIOD, 32'h20);
    wr(TIMER_ALARM_CTRL, 32'h3);
    run_until(64'h11);
    chk("per1_cmp",     cmp_value,    64'h30);
    chk("per1_pending", 64'(pending), 64'd1);
    chk("per1_overrun", 64'(overrun), 64'd0);
    run_until(64'h31);
    chk("per2_cmp",     cmp_value,    64'h50);
    chk("per2_overrun", 64'(overrun), 64'(OVR_EN));
    run_until(64'h51);
    chk("per3_cmp",     cmp_value,    64'h70);
    chk("model_cmp",    m.cmp,        64'h70);
`ifdef TIMER_ALARM_OVERRUN_EN
    chk("per3_miss",    64'(miss_cnt), 64'd2);
`endif

    // Wrap-around of the counter
    wr(TIMER_ALARM_CTRL, 32'hC);
    timer_value = 64'hFFFF_FFFF_FFFF_FFF0;
    wr(TIMER_ALARM_CMP_LOW, 32'h8);
    wr(TIMER_ALARM_CMP_HIGH, 32'h0);
    wr(TIMER_ALARM_PERIOD, 32'h10);
    wr(TIMER_ALARM_CTRL, 32'h3);
    run_until(64'h8);
    chk("wrap_nofire", 64'(pending), 64'd0);
    run_until(64'h9);
    chk("wrap_cmp",     cmp_value,    64'h18);
    chk("wrap_pending", 64'(pending), 64'd1);

    // Fire coincident with clear-pending, then with disarm
    wr(TIMER_ALARM_CTRL, 32'hC);
    timer_value = 64'd0;
    wr(TIMER_ALARM_CMP_LOW, 32'h20);
    wr(TIMER_ALARM_CMP_HIGH, 32'h0);
    wr(TIMER_ALARM_PERIOD, 32'h10);
    wr(TIMER_ALARM_CTRL, 32'h3);
    run_until(64'h21);
    chk("sim_first_fire", 64'(pending), 64'd1);
    run_until(64'h30);
    wr(TIMER_ALARM_CTRL, 32'h7);
    chk("sim_fire_clr_pending", 64'(pending), 64'd1);
    chk("sim_fire_clr_cmp",     cmp_value,    64'h40);
    chk("model_pending",        64'(m.pending), 64'd1);
    run_until(64'h35);
    wr(TIMER_ALARM_CTRL, 32'h7);
    chk("sim_clr_only", 64'(pending), 64'd0);
    run_until(64'h40);
    wr(TIMER_ALARM_CTRL, 32'h0);
    chk("sim_disarm_armed",   64'(armed),   64'd0);
    chk("sim_disarm_pending", 64'(pending), 64'd0);
    chk("sim_disarm_cmp",     cmp_value,    64'h40);

    // Arm while already reached: fire lands one cycle after arming
    wr(TIMER_ALARM_CTRL, 32'h1);
    chk("arm_reached_armed",   64'(armed),   64'd1);
    chk("arm_reached_pending", 64'(pending), 64'd0);
    cyc();
    chk("arm_reached_fire",  64'(pending), 64'd1);
    chk("arm_reached_done",  64'(armed),   64'd0);

    // Fire coincident with CMP_HIGH commit
    wr(TIMER_ALARM_CTRL, 32'hC);
    timer_value = 64'd0;
    wr(TIMER_ALARM_CMP_LOW, 32'h20);
    wr(TIMER_ALARM_CMP_HIGH, 32'h0);
    wr(TIMER_ALARM_PERIOD, 32'h10);
    wr(TIMER_ALARM_CTRL, 32'h3);
    wr(TIMER_ALARM_CMP_LOW, 32'h100);
    run_until(64'h20);
    wr(TIMER_ALARM_CMP_HIGH, 32'h0);
    chk("hi_fire_cmp",     cmp_value,    64'h100);
    chk("hi_fire_pending", 64'(pending), 64'd1);
    chk("hi_fire_armed",   64'(armed),   64'd1);

    // Atomic compare update across a long gap
    wr(TIMER_ALARM_CTRL, 32'hC);
    timer_value = 64'h1000;
    wr(TIMER_ALARM_CMP_LOW, 32'hF000_0000);
    wr(TIMER_ALARM_CMP_HIGH, 32'h0);
    wr(TIMER_ALARM_CTRL, 32'h1);
    wr(TIMER_ALARM_CMP_LOW, 32'h500);
    repeat (50) cyc();
    chk("atomic_gap_cmp",     cmp_value,    64'hF000_0000);
    chk("atomic_gap_pending", 64'(pending), 64'd0);
    wr(TIMER_ALARM_CMP_HIGH, 32'h1);
    chk("atomic_commit_cmp", cmp_value,  64'h1_0000_0500);
    chk("atomic_armed",      64'(armed), 64'd1);
    repeat (10) cyc();
    chk("atomic_nofire", 64'(pending), 64'd0);

    // Reset mid-operation with a coincident write
    rst       = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = TIMER_ALARM_CTRL;
    cfg_wdata = 32'h3;
    cyc();
    rst = 1'b0;
    chk("rst_mid_armed", 64'(armed),   64'd0);
    chk("rst_mid_cmp",   cmp_value,    64'd0);
    chk("rst_mid_pend",  64'(pending), 64'd0);
    repeat (5) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
